sram_like_port: RTL and testbench

//  Parametrised memory-stage port: bridges one pipeline stage's load/store (or fetch) op to an

---
 rtl/sram_like_port.sv | 183 ++++++++++++++++++
 tb/tb_sram_like_port.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_port.sv
// sram_like_port
//   Memory-stage port: turns one pipeline stage's load/store (or fetch) op
//   into a request on an SRAM-like bus (req/addr_ok/data_ok), generates the
//   stage stall, captures read data and silently drops the responses of ops
//   that were flushed after their request had been accepted. Up to
//   MAX_OUTSTANDING accepted-but-unanswered requests (orphans included) may
//   be in flight; the bus answers them in order.
//
// Parameters
//   AW               address width
//   DW               data width (power of two, >= 32)
//   MAX_OUTSTANDING  accepted-but-unanswered request limit (>= 1)
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   s_valid          stage holds a memory op
//   s_wr, s_size     op is a store / access size (00 byte, 01 half, 10 word)
//   s_addr, s_wdata  op address / store data
//   s_advance        stage register loads a new op this cycle
//   flush            kill the current op; its response is dropped
//   stall            stage must hold (combinational)
//   rdata_out        last captured own response data
//   rdata_valid      one-cycle pulse, rdata_out just updated
//   addr_err         one-cycle pulse, misaligned op rejected
//   req, wr, size    bus request / write / size
//   addr, wdata      bus address / write data
//   rdata            bus read data
//   addr_ok          bus accepted the request
//   data_ok          bus completed the oldest outstanding request
//
// Build option
//   SRAM_PORT_ALIGN_CHECK_EN: misaligned half/word ops are never issued;
//   they raise addr_err and complete immediately. Without it no alignment
//   check is done and addr_err is tied 0.

module sram_like_port #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    input  logic          s_wr,
    input  logic [1:0]    s_size,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_wdata,
    input  logic          s_advance,
    input  logic          flush,
    output logic          stall,
    output logic [DW-1:0] rdata_out,
    output logic          rdata_valid,
    output logic          addr_err,
    output logic          req,
    output logic          wr,
    output logic [1:0]    size,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    input  logic          addr_ok,
    input  logic          data_ok
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW:0] MAX_O = MAX_OUTSTANDING[OW:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t        state;
    logic [OW-1:0] orphan_cnt;
    logic          done;
    logic          killed;     // flushed while its request was still being offered

    logic          own_data_ok;
    logic          orphan_ret;
    logic          orphan_new;
    logic          room;
    logic          misaligned;

    // Responses are in order: while orphans exist, data_ok belongs to them.
    assign own_data_ok = (state == WAIT) && data_ok && (orphan_cnt == '0);
    assign orphan_ret  = data_ok && (orphan_cnt != '0);

    // The own request becomes an orphan when it is accepted after a kill,
    // or when flushed while waiting (unless its own answer arrives now).
    assign orphan_new  = ((state == WAIT) && flush && !own_data_ok) ||
                         ((state == REQ) && addr_ok && (killed || flush));

    // In IDLE the outstanding count is just the orphans.
    assign room        = ({1'b0, orphan_cnt} < MAX_O);

    assign stall       = s_valid && !flush && !(done || own_data_ok);

`ifdef SRAM_PORT_ALIGN_CHECK_EN
    assign misaligned  = ((s_size == 2'b01) && s_addr[0]) ||
                         ((s_size == 2'b10) && (s_addr[1:0] != 2'b00));
`else
    assign misaligned  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            orphan_cnt  <= '0;
            done        <= 1'b0;
            killed      <= 1'b0;
            req         <= 1'b0;
            wr          <= 1'b0;
            size        <= '0;
            addr        <= '0;
            wdata       <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;

            // An orphan born and another retired in the same cycle cancel out.
            if (orphan_new && !orphan_ret) begin
                orphan_cnt <= orphan_cnt + OW'(1);
            end else if (!orphan_new && orphan_ret) begin
                orphan_cnt <= orphan_cnt - OW'(1);
            end

            if (flush || s_advance) begin
                done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s_valid && !done && !flush) begin
                        if (misaligned) begin
                            addr_err <= 1'b1;
                            done     <= !s_advance;
                        end else if (room) begin
                            state  <= REQ;
                            req    <= 1'b1;
                            wr     <= s_wr;
                            size   <= s_size;
                            addr   <= s_addr;
                            wdata  <= s_wdata;
                            killed <= 1'b0;
                        end
                    end
                end

                REQ: begin
                    // A request is never retracted; a kill only takes effect
                    // once the bus has accepted it.
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    if (addr_ok) begin
                        req    <= 1'b0;
                        killed <= 1'b0;
                        state  <= (killed || flush) ? IDLE : WAIT;
                    end
                end

                WAIT: begin
                    if (own_data_ok) begin
                        state <= IDLE;
                        if (!flush) begin
                            rdata_out   <= rdata;
                            rdata_valid <= 1'b1;
                            done        <= !s_advance;
                        end
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_port.sv
// Self-checking bench for sram_like_port: the bench plays both the pipeline
// stage and the bus. Every own response it returns pushes the expected
// rdata_out onto a scoreboard; each rdata_valid pulse pops and compares.

module tb_sram_like_port;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid;
    logic          s_wr;
    logic [1:0]    s_size;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_advance;
    logic          flush;
    logic          stall;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic          addr_err;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          addr_ok;
    logic          data_ok;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] sb_exp;
    bit            mon_en = 1'b0;

    sram_like_port #(
        .AW              (AW),
        .DW              (DW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_valid     (s_valid),
        .s_wr        (s_wr),
        .s_size      (s_size),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_advance   (s_advance),
        .flush       (flush),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .addr_err    (addr_err),
        .req         (req),
        .wr          (wr),
        .size        (size),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles start 1 time unit after the rising edge; checks sit 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_valid   = 1'b0;
        s_wr      = 1'b0;
        s_size    = 2'b00;
        s_addr    = '0;
        s_wdata   = '0;
        s_advance = 1'b0;
        flush     = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rdata     = '0;
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_wr    = w;
        s_size  = sz;
        s_addr  = a;
        s_wdata = d;
    endtask

    // Scoreboard consumer: every rdata_valid pulse must match the oldest
    // expected own response.
    always @(negedge clk) begin
        if (mon_en && rdata_valid) begin
            if (sb_q.size() == 0) begin
                check("rdv_spurious", rdata_valid, 1'b0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("rdata_out", rdata_out, sb_exp);
            end
        end
    end

    initial begin
        clr();
        rstn = 1'b0;
        step();
        step();
        #1;
        check("rst_req", req, 1'b0);
        check("rst_wr", wr, 1'b0);
        check("rst_size", size, 2'b00);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_rdata_out", rdata_out, 0);
        check("rst_rdata_valid", rdata_valid, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_stall", stall, 1'b0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        step();

        // 1: load 0x100, addr_ok in cycle 1, data_ok in cycle 3
        op(1'b0, 2'b10, 32'h100, '0);
        #1;
        check("t1_stall_c0", stall, 1'b1);
        check("t1_req_c0", req, 1'b0);
        step();
        addr_ok = 1'b1;
        #1;
        check("t1_req_c1", req, 1'b1);
        check("t1_addr_c1", addr, 32'h100);
        check("t1_wr_c1", wr, 1'b0);
        check("t1_stall_c1", stall, 1'b1);
        step();
        addr_ok = 1'b0;
        #1;
        check("t1_req_c2", req, 1'b0);
        check("t1_stall_c2", stall, 1'b1);
        step();
        data_ok = 1'b1;
        rdata   = 32'hDEADBEEF;
        sb_q.push_back(32'hDEADBEEF);
        #1;
        check("t1_stall_c3", stall, 1'b0);
        step();
        data_ok = 1'b0;
        rdata   = '0;
        #1;
        check("t1_stall_done", stall, 1'b0);
        check("t1_rdata_out", rdata_out, 32'hDEADBEEF);
        s_advance = 1'b1;
        step();
        clr();
        #1;
        check("t1_no_reissue", req, 1'b0);
        check("t1_rdv_single", rdata_valid, 1'b0);
        step();

        // 2: store word, addr_ok withheld three cycles
        op(1'b1, 2'b10, 32'h200, 32'h12345678);
        #1;
        check("t2_stall_c0", stall, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            addr_ok = (i == 3);
            #1;
            check("t2_req", req, 1'b1);
            check("t2_wr", wr, 1'b1);
            check("t2_size", size, 2'b10);
            check("t2_addr", addr, 32'h200);
            check("t2_wdata", wdata, 32'h12345678);
            check("t2_stall", stall, 1'b1);
            step();
        end
        addr_ok = 1'b0;
        #1;
        check("t2_req_wait", req, 1'b0);
        check("t2_stall_wait", stall, 1'b1);
        step();
        data_ok = 1'b1;
        rdata   = 32'hDEADBEEF;
        sb_q.push_back(32'hDEADBEEF);
        #1;
        check("t2_stall_end", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        step();

        // 3: flush in WAIT, next load's response follows the orphan's
        op(1'b0, 2'b10, 32'h300, '0);
        step();
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        flush   = 1'b1;
        #1;
        check("t3_stall_flush", stall, 1'b0);
        step();
        flush = 1'b0;
        op(1'b0, 2'b10, 32'h304, '0);
        #1;
        check("t3_stall_new", stall, 1'b1);
        step();
        addr_ok = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h1111;
        #1;
        check("t3_req_new", req, 1'b1);
        check("t3_addr_new", addr, 32'h304);
        check("t3_stall_orphan", stall, 1'b1);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        #1;
        check("t3_stall_wait", stall, 1'b1);
        check("t3_drop", rdata_out, 32'hDEADBEEF);
        step();
        data_ok = 1'b1;
        rdata   = 32'h2222;
        sb_q.push_back(32'h2222);
        #1;
        check("t3_stall_own", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        step();

        // 4: two orphans outstanding block a third op until one returns
        op(1'b0, 2'b10, 32'h400, '0);
        step();
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        op(1'b0, 2'b10, 32'h404, '0);
        step();
        addr_ok = 1'b1;
        #1;
        check("t4_req_b", req, 1'b1);
        step();
        addr_ok = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        op(1'b0, 2'b10, 32'h408, '0);
        #1;
        check("t4_req_blocked", req, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                data_ok = 1'b1;
                rdata   = 32'hAAAA;
            end
            #1;
            check("t4_req_full", req, 1'b0);
            check("t4_stall_full", stall, 1'b1);
            step();
        end
        data_ok = 1'b0;
        rdata   = '0;
        #1;
        check("t4_req_pre", req, 1'b0);
        check("t4_stall_pre", stall, 1'b1);
        step();
        addr_ok = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'hBBBB;
        #1;
        check("t4_req_c", req, 1'b1);
        check("t4_addr_c", addr, 32'h408);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        #1;
        check("t4_req_wait", req, 1'b0);
        check("t4_stall_wait", stall, 1'b1);
        step();
        data_ok = 1'b1;
        rdata   = 32'hC0C0;
        sb_q.push_back(32'hC0C0);
        #1;
        check("t4_stall_own", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        step();

        // 5: reset while waiting with an orphan outstanding
        op(1'b0, 2'b10, 32'h500, '0);
        step();
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        op(1'b0, 2'b10, 32'h504, '0);
        step();
        addr_ok = 1'b1;
        step();
        clr();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        check("t5_req", req, 1'b0);
        check("t5_stall", stall, 1'b0);
        check("t5_rdata_out", rdata_out, 0);
        check("t5_rdata_valid", rdata_valid, 1'b0);
        step();
        // Minimum latency; a surviving orphan would swallow this data_ok.
        op(1'b0, 2'b10, 32'h600, '0);
        step();
        addr_ok = 1'b1;
        #1;
        check("t5_req_d", req, 1'b1);
        check("t5_addr_d", addr, 32'h600);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'hD00D;
        sb_q.push_back(32'hD00D);
        #1;
        check("t5_stall_min_lat", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        step();

        // 6: misaligned word load at 0x102
        op(1'b0, 2'b10, 32'h102, '0);
`ifdef SRAM_PORT_ALIGN_CHECK_EN
        #1;
        check("t6_stall_c0", stall, 1'b1);
        step();
        #1;
        check("t6_addr_err", addr_err, 1'b1);
        check("t6_req", req, 1'b0);
        check("t6_stall_c1", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        #1;
        check("t6_addr_err_pulse", addr_err, 1'b0);
        check("t6_req_after", req, 1'b0);
        step();
`else
        step();
        addr_ok = 1'b1;
        #1;
        check("t6_req", req, 1'b1);
        check("t6_addr", addr, 32'h102);
        check("t6_addr_err", addr_err, 1'b0);
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h0102;
        sb_q.push_back(32'h0102);
        #1;
        check("t6_stall", stall, 1'b0);
        s_advance = 1'b1;
        step();
        clr();
        step();
`endif

        step();
        step();
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
